// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the RV64I front end.
//   fetch_entry_t  - one prefetch queue entry {pc, instr}
//   INSTR_NOP      - canonical NOP (addi x0, x0, 0) shown to decode after reset
//   OP_*           - major opcodes, shared with decode and the immediate generator
//   opcode_of()    - extracts the major opcode field from an instruction word
package core_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with explicit occupancy count and flush.
//   clk, reset       - clock, synchronous active-high reset (empties the FIFO)
//   flush            - empties the FIFO; overrides any write/read that cycle
//   wr_en, wr_data   - enqueue at the tail (ignored when full)
//   rd_en            - pop the head (ignored when empty)
//   rd_data          - head entry, read combinationally from storage
//   count, empty     - occupancy and its zero flag
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Per-entry write strobes; nothing is written in a flush cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign entry_we[gi] = wr_ok && !flush && (tail_q == AW'(gi));
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) tail_d = tail_q + 1'b1;
            if (rd_ok) head_d = head_q + 1'b1;
            // Pointers wrap naturally; the separate count keeps full/empty unambiguous.
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) mem_q[i] <= wr_data;
        end
    end

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a small prefetch queue.
//   clk, reset                - core clock, synchronous active-high reset
//   imem_req, imem_addr       - request to a 1-cycle-latency instruction memory
//   imem_rdata                - returned word, valid the cycle after a request
//   redirect, redirect_pc     - flush the queue and restart fetch at redirect_pc
//   id_valid/id_instr/id_pc   - head entry presented to decode
//   id_ready                  - decode accepts the head this cycle
//   count                     - current queue occupancy
module fetch_queue
    import core_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [63:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [63:0]   redirect_pc,
    output logic          id_valid,
    output logic [31:0]   id_instr,
    output logic [63:0]   id_pc,
    input  logic          id_ready,
    output logic [CW-1:0] count
);

    logic [63:0]  fetch_pc_q, fetch_pc_d;
    logic [63:0]  req_pc_q, req_pc_d;       // PC of the request now in flight
    logic         inflight_q, inflight_d;
    fetch_entry_t head_hold_q, head_hold_d; // last entry shown to decode

    fetch_entry_t fifo_wr_data;
    fetch_entry_t fifo_rd_data;
    fetch_entry_t head_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [CW:0]   demand;
    logic          enq;
    logic          deq;

    // Counting the in-flight word against capacity reserves its slot, so a
    // response can always be written and there is never more than one in flight.
    // id_ready is deliberately absent from this path.
    assign demand   = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign imem_req = !reset && !redirect && (demand < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign enq = inflight_q && !redirect && !reset;
    assign deq = id_ready && !fifo_empty && !redirect && !reset;

    assign fifo_wr_data = '{pc: req_pc_q, instr: imem_rdata};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (enq),
        .wr_data (fifo_wr_data),
        .rd_en   (deq),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // While empty, decode keeps seeing whatever it saw last (NOP after reset).
    assign head_entry  = fifo_empty ? head_hold_q : fifo_rd_data;
    assign head_hold_d = head_entry;

    assign id_valid = !fifo_empty;
    assign id_instr = head_entry.instr;
    assign id_pc    = head_entry.pc;
    assign count    = fifo_count;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~64'h3;
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            req_pc_d   = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            head_hold_q <= '{pc: 64'h0, instr: INSTR_NOP};
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            head_hold_q <= head_hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (DEPTH=4).
// The instruction memory returns a word derived from the address one cycle
// after each request; every decode handshake is matched against a queue of
// expected PCs pushed when the fetch stream is (re)started.
module tb_fetch_queue;
    import core_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [63:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [63:0]   id_pc;
    logic          id_ready;
    logic [CW-1:0] count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BD0;
    endfunction

    // 1-cycle synchronous instruction memory; garbage when no request was made.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_stream(input logic [63:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 64'(4 * i));
    endtask

    // Inputs for the coming edge are already driven; observe the handshake
    // that edge will perform, then advance to the next falling edge.
    task automatic tick();
        logic [63:0] e;
        #1;
        check("count_bound", 64'(int'(count) <= DEPTH), 64'd1);
        if (!reset && !redirect && id_valid && id_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL deq_unexpected: got pc %0h, expected no handshake", id_pc);
            end else begin
                e = exp_q.pop_front();
                check("deq_pc", id_pc, e);
                check("deq_instr", 64'(id_instr), 64'(word_of(e)));
                $display("deq pc=%0h instr=%08h count=%0d", id_pc, id_instr, count);
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        logic [3:0]  exp_count;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int hs_start;

        // Reset release with id_ready=1: addresses 0,4,8,...; first valid at cycle 2.
        vecs[0] = '{1'b0, 1'b1, 1'b1, 64'd0,  1'b0, 64'd0,  INSTR_NOP,      4'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 64'd4,  1'b0, 64'd0,  INSTR_NOP,      4'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 64'd8,  1'b1, 64'd0,  word_of(64'd0), 4'd1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 64'd12, 1'b1, 64'd4,  word_of(64'd4), 4'd1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 64'd16, 1'b1, 64'd8,  word_of(64'd8), 4'd1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 64'd20, 1'b1, 64'd12, word_of(64'd12), 4'd1};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        id_ready    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req",   64'(imem_req), 64'd0);
        check("rst_valid", 64'(id_valid), 64'd0);
        check("rst_count", 64'(count),    64'd0);
        check("rst_instr", 64'(id_instr), 64'(INSTR_NOP));
        check("rst_pc",    id_pc,         64'd0);

        expect_stream(RESET_PC);
        for (int i = 0; i < 6; i++) begin
            reset    = vecs[i].rst;
            id_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_req", i),   64'(imem_req), 64'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i),  imem_addr,     vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), 64'(id_valid), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_pc", i),    id_pc,         vecs[i].exp_pc);
            check($sformatf("v%0d_instr", i), 64'(id_instr), 64'(vecs[i].exp_instr));
            check($sformatf("v%0d_count", i), 64'(count),    64'(vecs[i].exp_count));
            $display("vec %0d addr=%0h valid=%0b pc=%0h count=%0d", i, imem_addr, id_valid, id_pc, count);
            tick();
        end

        // Fill to DEPTH with id_ready low, then free one slot.
        reset    = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        expect_stream(RESET_PC);
        reset = 1'b0;
        repeat (8) tick();
        check("full_count", 64'(count),    64'd4);
        check("full_req",   64'(imem_req), 64'd0);
        check("full_valid", 64'(id_valid), 64'd1);
        check("full_pc",    id_pc,         64'd0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        check("free_count", 64'(count),    64'd3);
        check("free_req",   64'(imem_req), 64'd1);
        check("free_addr",  imem_addr,     64'd16);
        tick();
        check("refill_count_infl", 64'(count),    64'd3);
        check("refill_req_infl",   64'(imem_req), 64'd0);
        tick();
        check("refill_count", 64'(count), 64'd4);
        check("refill_pc",    id_pc,      64'd4);
        $display("full/refill done count=%0d head=%0h", count, id_pc);

        // Redirect with 3 queued and one request in flight.
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        check("pre_redir_addr", imem_addr, 64'd20);
        tick();
        check("pre_redir_count", 64'(count),    64'd3);
        check("pre_redir_req",   64'(imem_req), 64'd0);
        redirect    = 1'b1;
        redirect_pc = 64'h1002;
        #1;
        check("redir_req", 64'(imem_req), 64'd0);
        expect_stream(64'h1000);
        tick();
        redirect = 1'b0;
        #1;
        check("post_redir_count", 64'(count),    64'd0);
        check("post_redir_valid", 64'(id_valid), 64'd0);
        check("post_redir_req",   64'(imem_req), 64'd1);
        check("post_redir_addr",  imem_addr,     64'h1000);
        $display("redirect to 1002 -> addr=%0h count=%0d", imem_addr, count);
        id_ready = 1'b1;
        repeat (6) tick();

        // Redirect coinciding with a decode handshake.
        check("hs_redir_valid_before", 64'(id_valid), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        id_ready    = 1'b1;
        expect_stream(64'h2000);
        tick();
        redirect = 1'b0;
        #1;
        check("hs_redir_count", 64'(count),    64'd0);
        check("hs_redir_valid", 64'(id_valid), 64'd0);
        check("hs_redir_req",   64'(imem_req), 64'd1);
        check("hs_redir_addr",  imem_addr,     64'h2000);
        $display("redirect+handshake -> addr=%0h count=%0d", imem_addr, count);

        // Sustained flow with random single-cycle stalls.
        hs_start = hs_cnt;
        for (int i = 0; i < 200; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("stall_progress", 64'((hs_cnt - hs_start) >= 100), 64'd1);

        // Reset while full.
        id_ready = 1'b0;
        repeat (8) tick();
        check("prereset_count", 64'(count), 64'd4);
        reset = 1'b1;
        #1;
        check("reset_req_now", 64'(imem_req), 64'd0);
        tick();
        check("midrst_count", 64'(count),    64'd0);
        check("midrst_valid", 64'(id_valid), 64'd0);
        check("midrst_req",   64'(imem_req), 64'd0);
        check("midrst_instr", 64'(id_instr), 64'(INSTR_NOP));
        check("midrst_pc",    id_pc,         64'd0);
        expect_stream(RESET_PC);
        reset = 1'b0;
        #1;
        check("restart_req",  64'(imem_req), 64'd1);
        check("restart_addr", imem_addr,     RESET_PC);
        id_ready = 1'b1;
        hs_start = hs_cnt;
        repeat (10) tick();
        check("restart_progress", 64'((hs_cnt - hs_start) >= 7), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage with a small prefetch queue for the RV64I core. Sits directly upstream of decode and the immediate generator.
- Generates sequential PCs and issues requests to a fixed-latency (1-cycle) synchronous instruction memory.
- Buffers returned words with their PCs and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  64  byte address of the request; always equal to fetch_pc.
- imem_rdata  input  32  instruction word; valid exactly one cycle after a request.
- redirect  input  1  taken branch/jump: flush and restart fetch.
- redirect_pc  input  64  new fetch PC; bits [1:0] are ignored and treated as 0.
- id_valid  output  1  head entry available to decode.
- id_instr  output  32  head instruction word; feeds the immediate generator.
- id_pc  output  64  PC of the head instruction.
- id_ready  input  1  decode accepts the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, active-high), applied to every output and register:
  - fetch_pc=RESET_PC; queue empty (count=0); inflight=0; imem_req=0.
  - id_valid=0; id_instr=32'h0000_0013 (NOP); id_pc=0.
  - Reset asserted mid-operation: any in-flight response is dropped, and no enqueue occurs in that cycle.
- Request rule:
  - imem_req = !reset && !redirect && (count + inflight < DEPTH). This is combinational from registered state plus redirect.
  - When imem_req=1: fetch_pc <= fetch_pc+4 (64-bit wrap, no trap), and inflight <= 1; otherwise inflight <= 0.
  - The rule guarantees at most one outstanding request and guarantees the queue never overflows.
- Response: if inflight=1 and no redirect/reset this cycle, enqueue {pc_of_request, imem_rdata} at the tail. pc_of_request is a register captured at request time.
- Dequeue: a handshake occurs when id_valid && id_ready; the head pointer advances.
- id_valid = (count != 0). id_instr/id_pc are the head entry, read combinationally from queue storage. When the queue is empty they hold their last values.
- Latency: a request issued at cycle t returns data at t+1, is written at the end of t+1, and shows id_valid=1 at t+2. Minimum fetch-to-decode latency is 2 cycles.
- Steady state with id_ready=1: one instruction per cycle.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- Full queue (count=DEPTH): imem_req=0; id_valid stays 1. A dequeue frees a slot, and a request may issue the following cycle.
- Empty queue with id_ready=1: no handshake; count stays 0.
- Redirect (highest priority after reset):
  - In the cycle redirect=1: no request, no enqueue (the in-flight response is discarded), and any dequeue handshake is ignored.
  - Next state: count=0, pointers=0, inflight=0, fetch_pc=redirect_pc & ~64'h3.
  - The first request at the new PC issues in the cycle after redirect.
- Pointers: $clog2(DEPTH)-bit head/tail that wrap naturally. count tracks occupancy separately so that full and empty are unambiguous.
- No combinational path from id_ready to imem_req. imem_req depends only on registered count/inflight, reset and redirect.

Decomposition:
- Package core_pkg holds:
  - fetch_entry_t (packed: pc[63:0], instr[31:0]).
  - The NOP constant 32'h0000_0013.
  - Opcode localparams (OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_IMM_32, SYSTEM), shared with the immediate generator and decode.
- Sub-module sync_fifo: parameterised by WIDTH and DEPTH; storage, pointers, count, and a flush input. fetch_queue instantiates it with WIDTH=$bits(fetch_entry_t).

Test Plan:
- Reset release with id_ready=1 and imem returning addr-derived words -> imem_addr=0,4,8,... on consecutive cycles; first id_valid at cycle 2 with id_pc=0; thereafter one instruction per cycle with id_pc incrementing by 4.
- id_ready=0 held after reset, DEPTH=4 -> count reaches 4; imem_req=0 from then on; head stays at id_pc=0. Raise id_ready for 1 cycle -> count=3, then one request issues (addr=16) and count returns to 4.
- Redirect to 64'h1002 while 3 entries are queued and a request is in flight -> next cycle count=0 and id_valid=0; the following cycle imem_addr=64'h1000; the discarded in-flight word never appears at id_instr.
- Redirect asserted in the same cycle as id_valid&&id_ready -> dequeue ignored; state identical to a redirect without a handshake.
- Sustained id_ready=1 with random 1-cycle stalls -> id_pc stream is gap-free and in order; count never exceeds 4; no word is duplicated or lost.
- Reset asserted mid-stream while full -> next cycle count=0, id_valid=0, imem_req=0; after release fetch restarts at RESET_PC.
